// File: rtl/rpn_sequencer.sv
// rtl/rpn_sequencer.sv - control FSM sequencing stack pops, ALU op and result push for the RPN calculator
module rpn_sequencer #(
  parameter int WORD_WIDTH = 8,
  parameter int STACK_SIZE = 8,
  localparam int DEPTH_W = $clog2(STACK_SIZE + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_op,
  input  logic [2:0]            in_op,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  stack_push,
  output logic                  stack_pop,
  output logic [WORD_WIDTH-1:0] stack_write_data,
  input  logic [WORD_WIDTH-1:0] stack_read_data,
  output logic [DEPTH_W-1:0]    depth,
  output logic                  err_underflow,
  output logic                  err_overflow,
  input  logic                  err_clear
);

  typedef enum logic [1:0] {IDLE, OP_B, PUSH} state_t;

  localparam logic [2:0] OP_NEG  = 3'd6;
  localparam logic [2:0] OP_DROP = 3'd7;
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_SIZE);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

  state_t                  state, state_nxt;
  logic [DEPTH_W-1:0]      depth_nxt;
  logic [WORD_WIDTH-1:0]   opa, opa_nxt;
  logic [WORD_WIDTH-1:0]   result, result_nxt;
  logic [2:0]              op_q, op_nxt;
  logic                    push_c, pop_c;
  logic                    uf_set, of_set;
  logic                    accept;

  // b is the deeper operand, a was the top of stack when the op was accepted
  function automatic logic [WORD_WIDTH-1:0] alu(input logic [2:0] op,
                                                input logic [WORD_WIDTH-1:0] b,
                                                input logic [WORD_WIDTH-1:0] a);
    case (op)
      3'd0:    alu = b + a;
      3'd1:    alu = b - a;
      3'd2:    alu = b * a;
      3'd3:    alu = b & a;
      3'd4:    alu = b | a;
      3'd5:    alu = b ^ a;
      default: alu = '0;
    endcase
  endfunction

  assign in_ready = (state == IDLE) & reset_n;
  assign accept   = in_valid & in_ready;

  // stack strobes are held low while reset is asserted so the stack sees no activity
  assign stack_push = push_c & reset_n;
  assign stack_pop  = pop_c & reset_n;

  // state, depth, operand/result and sticky error registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      depth         <= '0;
      opa           <= '0;
      result        <= '0;
      op_q          <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state         <= state_nxt;
      depth         <= depth_nxt;
      opa           <= opa_nxt;
      result        <= result_nxt;
      op_q          <= op_nxt;
      err_underflow <= uf_set | (err_underflow & ~err_clear);
      err_overflow  <= of_set | (err_overflow & ~err_clear);
    end
  end

  // next-state, stack strobes and error events
  always_comb begin
    state_nxt        = state;
    depth_nxt        = depth;
    opa_nxt          = opa;
    result_nxt       = result;
    op_nxt           = op_q;
    push_c           = 1'b0;
    pop_c            = 1'b0;
    stack_write_data = '0;
    uf_set           = 1'b0;
    of_set           = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!in_is_op) begin
            if (depth < DEPTH_FULL) begin
              push_c           = 1'b1;
              stack_write_data = in_data;
              depth_nxt        = depth + DEPTH_ONE;
            end else begin
              of_set = 1'b1;
            end
          end else if (in_op == OP_NEG) begin
            if (depth != '0) begin
              result_nxt = -stack_read_data;
              pop_c      = 1'b1;
              depth_nxt  = depth - DEPTH_ONE;
              state_nxt  = PUSH;
            end else begin
              uf_set = 1'b1;
            end
          end else if (in_op == OP_DROP) begin
            if (depth != '0) begin
              pop_c     = 1'b1;
              depth_nxt = depth - DEPTH_ONE;
            end else begin
              uf_set = 1'b1;
            end
          end else begin
            if (depth < DEPTH_TWO) begin
              uf_set = 1'b1;
            end else begin
              opa_nxt   = stack_read_data;
              op_nxt    = in_op;
              pop_c     = 1'b1;
              depth_nxt = depth - DEPTH_ONE;
              state_nxt = OP_B;
            end
          end
        end
      end
      OP_B: begin
        result_nxt = alu(op_q, stack_read_data, opa);
        pop_c      = 1'b1;
        depth_nxt  = depth - DEPTH_ONE;
        state_nxt  = PUSH;
      end
      PUSH: begin
        push_c           = 1'b1;
        stack_write_data = result;
        depth_nxt        = depth + DEPTH_ONE;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb/tb_rpn_sequencer.sv - self-checking bench for rpn_sequencer with a behavioural stack
module tb_rpn_sequencer;
  localparam int W  = 8;
  localparam int SS = 8;
  localparam int DW = $clog2(SS + 1);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_is_op = 1'b0;
  logic [2:0]    in_op = '0;
  logic [W-1:0]  in_data = '0;
  logic          stack_push;
  logic          stack_pop;
  logic [W-1:0]  stack_write_data;
  logic [W-1:0]  stack_read_data;
  logic [DW-1:0] depth;
  logic          err_underflow;
  logic          err_overflow;
  logic          err_clear = 1'b0;

  int checks = 0;
  int failures = 0;
  int pop_cnt = 0;

  rpn_sequencer #(.WORD_WIDTH(W), .STACK_SIZE(SS)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_op(in_is_op),
    .in_op(in_op), .in_data(in_data),
    .stack_push(stack_push), .stack_pop(stack_pop),
    .stack_write_data(stack_write_data), .stack_read_data(stack_read_data),
    .depth(depth), .err_underflow(err_underflow), .err_overflow(err_overflow),
    .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  // behavioural top-of-stack unit, reset together with the DUT
  logic [W-1:0] mem [SS];
  int sp = 0;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) sp <= 0;
    else if (stack_push && sp < SS) begin
      mem[sp] <= stack_write_data;
      sp <= sp + 1;
    end else if (stack_pop && sp > 0) sp <= sp - 1;
  end
  assign stack_read_data = (sp > 0) ? mem[sp-1] : '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: expected push data queued at stimulus time, compared on each push pulse
  logic [W-1:0] sb_q[$];
  logic [W-1:0] ref_stk[$];
  logic [W-1:0] mon_exp;

  always @(negedge clock) begin
    if (reset_n) begin
      if (stack_pop) pop_cnt++;
      if (stack_push) begin
        check("pop_with_push", int'(stack_pop), 0);
        check("push_expected", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          mon_exp = sb_q.pop_front();
          check("push_data", int'(stack_write_data), int'(mon_exp));
        end
      end
    end
  end

  task automatic model_token(input logic is_op, input logic [2:0] op, input logic [W-1:0] data);
    logic [W-1:0] a, b, r;
    if (!is_op) begin
      if (ref_stk.size() < SS) begin
        ref_stk.push_back(data);
        sb_q.push_back(data);
      end
    end else if (op == 3'd6) begin
      if (ref_stk.size() >= 1) begin
        a = ref_stk.pop_back();
        r = 8'd0 - a;
        ref_stk.push_back(r);
        sb_q.push_back(r);
      end
    end else if (op == 3'd7) begin
      if (ref_stk.size() >= 1) void'(ref_stk.pop_back());
    end else if (ref_stk.size() >= 2) begin
      a = ref_stk.pop_back();
      b = ref_stk.pop_back();
      case (op)
        3'd0: r = b + a;
        3'd1: r = b - a;
        3'd2: r = W'((int'(b) * int'(a)) % 256);
        3'd3: r = b & a;
        3'd4: r = b | a;
        default: r = b ^ a;
      endcase
      ref_stk.push_back(r);
      sb_q.push_back(r);
    end
  endtask

  // called at posedge+1 with the DUT idle; returns cycles in_ready stayed low and pops seen
  task automatic send_token(input logic is_op, input logic [2:0] op, input logic [W-1:0] data,
                            output int busy, output int pops);
    int p0;
    p0 = pop_cnt;
    model_token(is_op, op, data);
    in_valid = 1'b1;
    in_is_op = is_op;
    in_op    = op;
    in_data  = data;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_is_op = 1'($urandom);
    in_op    = 3'($urandom);
    in_data  = W'($urandom);
    busy = 0;
    while (!in_ready && busy < 10) begin
      @(posedge clock);
      #1;
      busy++;
    end
    pops = pop_cnt - p0;
  endtask

  typedef struct {
    logic         is_op;
    logic [2:0]   op;
    logic [W-1:0] data;
    logic [W-1:0] top;
    int           dep;
    int           busy;
    int           pops;
    logic         uf;
    logic         of;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic is_op, input logic [2:0] op, input logic [W-1:0] data,
                     input logic [W-1:0] top, input int dep, input int busy, input int pops,
                     input logic uf, input logic of);
    vec_t v;
    v.is_op = is_op; v.op = op; v.data = data; v.top = top; v.dep = dep;
    v.busy = busy; v.pops = pops; v.uf = uf; v.of = of;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int busy, pops;

    //   op  code  data   top    dep busy pops uf of
    add(0, 0, 8'h03, 8'h03, 1, 0, 0, 0, 0);
    add(0, 0, 8'h05, 8'h05, 2, 0, 0, 0, 0);
    add(1, 0, 8'h00, 8'h08, 1, 2, 2, 0, 0);   // ADD
    add(1, 7, 8'h00, 8'h00, 0, 0, 1, 0, 0);   // DROP
    add(0, 0, 8'h03, 8'h03, 1, 0, 0, 0, 0);
    add(0, 0, 8'h05, 8'h05, 2, 0, 0, 0, 0);
    add(1, 1, 8'h00, 8'hFE, 1, 2, 2, 0, 0);   // SUB
    add(1, 7, 8'h00, 8'h00, 0, 0, 1, 0, 0);
    add(0, 0, 8'h10, 8'h10, 1, 0, 0, 0, 0);
    add(0, 0, 8'h20, 8'h20, 2, 0, 0, 0, 0);
    add(1, 2, 8'h00, 8'h00, 1, 2, 2, 0, 0);   // MUL
    add(0, 0, 8'h01, 8'h01, 2, 0, 0, 0, 0);
    add(1, 6, 8'h00, 8'hFF, 2, 1, 1, 0, 0);   // NEG
    add(1, 7, 8'h00, 8'h00, 1, 0, 1, 0, 0);
    add(1, 7, 8'h00, 8'h00, 0, 0, 1, 0, 0);
    add(1, 6, 8'h00, 8'h00, 0, 0, 0, 1, 0);   // NEG on empty
    add(0, 0, 8'h07, 8'h07, 1, 0, 0, 1, 0);
    add(1, 0, 8'h00, 8'h07, 1, 0, 0, 1, 0);   // ADD with one entry
    add(0, 0, 8'hF0, 8'hF0, 2, 0, 0, 1, 0);
    add(1, 3, 8'h00, 8'h00, 1, 2, 2, 1, 0);   // AND
    add(0, 0, 8'h0C, 8'h0C, 2, 0, 0, 1, 0);
    add(1, 4, 8'h00, 8'h0C, 1, 2, 2, 1, 0);   // OR
    add(0, 0, 8'h0A, 8'h0A, 2, 0, 0, 1, 0);
    add(1, 5, 8'h00, 8'h06, 1, 2, 2, 1, 0);   // XOR
    add(1, 7, 8'h00, 8'h00, 0, 0, 1, 1, 0);
    add(1, 7, 8'h00, 8'h00, 0, 0, 0, 1, 0);   // DROP on empty

    #2;
    check("reset_push", int'(stack_push), 0);
    check("reset_pop", int'(stack_pop), 0);
    check("reset_ready", int'(in_ready), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_depth", int'(depth), 0);
    check("rst_ready", int'(in_ready), 1);
    check("rst_uf", int'(err_underflow), 0);
    check("rst_of", int'(err_overflow), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      send_token(tbl[i].is_op, tbl[i].op, tbl[i].data, busy, pops);
      check($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("v%0d_pops", i), pops, tbl[i].pops);
      check($sformatf("v%0d_depth", i), int'(depth), tbl[i].dep);
      if (tbl[i].dep > 0) check($sformatf("v%0d_top", i), int'(stack_read_data), int'(tbl[i].top));
      check($sformatf("v%0d_uf", i), int'(err_underflow), int'(tbl[i].uf));
      check($sformatf("v%0d_of", i), int'(err_overflow), int'(tbl[i].of));
    end

    err_clear = 1'b1;
    @(posedge clock);
    #1;
    err_clear = 1'b0;
    check("clr_uf", int'(err_underflow), 0);
    check("clr_of", int'(err_overflow), 0);

    for (int i = 0; i < SS; i++) send_token(1'b0, 3'd0, W'(8'h11 + i), busy, pops);
    check("full_depth", int'(depth), SS);
    check("full_of_before", int'(err_overflow), 0);
    send_token(1'b0, 3'd0, 8'h99, busy, pops);
    check("ovf_busy", busy, 0);
    check("ovf_depth", int'(depth), SS);
    check("ovf_top", int'(stack_read_data), 8'h18);
    check("ovf_flag", int'(err_overflow), 1);

    err_clear = 1'b1;
    send_token(1'b0, 3'd0, 8'h55, busy, pops);
    err_clear = 1'b0;
    check("clr_vs_event_of", int'(err_overflow), 1);
    check("clr_vs_event_depth", int'(depth), SS);
    err_clear = 1'b1;
    @(posedge clock);
    #1;
    err_clear = 1'b0;
    check("clr2_of", int'(err_overflow), 0);

    for (int i = 0; i < SS; i++) send_token(1'b1, 3'd7, 8'h00, busy, pops);
    check("drain_depth", int'(depth), 0);

    send_token(1'b0, 3'd0, 8'h03, busy, pops);
    send_token(1'b0, 3'd0, 8'h05, busy, pops);
    in_valid = 1'b1;
    in_is_op = 1'b1;
    in_op    = 3'd0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("mid_in_opb", int'(in_ready), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_push", int'(stack_push), 0);
    check("mid_pop", int'(stack_pop), 0);
    check("mid_depth", int'(depth), 0);
    check("mid_ready", int'(in_ready), 0);
    ref_stk.delete();
    sb_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("post_ready", int'(in_ready), 1);
    check("post_depth0", int'(depth), 0);
    send_token(1'b0, 3'd0, 8'h04, busy, pops);
    check("post_top", int'(stack_read_data), 8'h04);
    check("post_depth", int'(depth), 1);

    repeat (3) @(posedge clock);
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
